exu_oitf: RTL

- Outstanding Instruction Track FIFO for the EXU.
- Sits between exu_disp and exu_longpwbck.
- Records every long-pipe instruction (load/store via AGU/LSU) at dispatch, and releases it in order when the long-pipe write-back retires.
- Flags RAW/WAW hazards against in-flight destinations so dispatch stalls; supplies the retiring entry's rdidx/rdwen/pc to the long-pipe write-back.

---
 rtl/exu_oitf.sv | 109 ++++++++++
 1 files changed

// File: rtl/exu_oitf.sv
// exu_oitf: outstanding instruction track FIFO for long-pipe instructions,
// with RAW/WAW hazard detection against in-flight destinations.
module exu_oitf #(
    parameter int DEPTH       = 2,
    parameter int PTR_W       = 1,
    parameter int RFIDX_WIDTH = 5,
    parameter int PC_SIZE     = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   dis_ready,
    input  logic                   dis_ena,
    input  logic                   ret_ena,
    output logic [PTR_W-1:0]       dis_ptr,
    output logic [PTR_W-1:0]       ret_ptr,
    output logic [RFIDX_WIDTH-1:0] ret_rdidx,
    output logic                   ret_rdwen,
    output logic [PC_SIZE-1:0]     ret_pc,
    input  logic                   disp_i_rs1en,
    input  logic                   disp_i_rs2en,
    input  logic                   disp_i_rdwen,
    input  logic [RFIDX_WIDTH-1:0] disp_i_rs1idx,
    input  logic [RFIDX_WIDTH-1:0] disp_i_rs2idx,
    input  logic [RFIDX_WIDTH-1:0] disp_i_rdidx,
    input  logic [PC_SIZE-1:0]     disp_i_pc,
    output logic                   oitfrd_match_disprs1,
    output logic                   oitfrd_match_disprs2,
    output logic                   oitfrd_match_disprd,
    output logic                   oitf_empty
);
    logic [DEPTH-1:0]       vld_q, vld_d;
    logic [DEPTH-1:0]       rdwen_q, rdwen_d;
    logic [RFIDX_WIDTH-1:0] rdidx_q [DEPTH];
    logic [RFIDX_WIDTH-1:0] rdidx_d [DEPTH];
    logic [PC_SIZE-1:0]     pc_q [DEPTH];
    logic [PC_SIZE-1:0]     pc_d [DEPTH];
    // Pointers carry their wrap flag in the MSB: {flag, index}.
    logic [PTR_W:0]         alc_q, alc_d, rtp_q, rtp_d;
    logic                   full, empty, alc_fire, ret_fire;
    logic                   m1, m2, md;

    assign dis_ptr    = alc_q[PTR_W-1:0];
    assign ret_ptr    = rtp_q[PTR_W-1:0];
    assign empty      = alc_q == rtp_q;
    assign full       = (dis_ptr == ret_ptr) && (alc_q[PTR_W] != rtp_q[PTR_W]);
    assign dis_ready  = ~full;
    assign oitf_empty = empty;
    assign alc_fire   = dis_ena & ~full;
    assign ret_fire   = ret_ena & ~empty;
    assign alc_d      = alc_q + (PTR_W+1)'(alc_fire);
    assign rtp_d      = rtp_q + (PTR_W+1)'(ret_fire);
    assign ret_rdidx  = rdidx_q[ret_ptr];
    assign ret_rdwen  = rdwen_q[ret_ptr];
    assign ret_pc     = pc_q[ret_ptr];

    always_comb begin
        vld_d   = vld_q;
        rdwen_d = rdwen_q;
        rdidx_d = rdidx_q;
        pc_d    = pc_q;
        if (ret_fire)
            vld_d[ret_ptr] = 1'b0;
        if (alc_fire) begin
            vld_d[dis_ptr]   = 1'b1;
            rdwen_d[dis_ptr] = disp_i_rdwen;
            rdidx_d[dis_ptr] = disp_i_rdidx;
            pc_d[dis_ptr]    = disp_i_pc;
        end
    end

    // Compare against registered state only: retiring entries still match,
    // entries allocated this cycle do not.
    always_comb begin
        m1 = 1'b0;
        m2 = 1'b0;
        md = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && rdwen_q[i]) begin
                m1 = m1 | (rdidx_q[i] == disp_i_rs1idx);
                m2 = m2 | (rdidx_q[i] == disp_i_rs2idx);
                md = md | (rdidx_q[i] == disp_i_rdidx);
            end
        end
    end

    assign oitfrd_match_disprs1 = m1 & disp_i_rs1en;
    assign oitfrd_match_disprs2 = m2 & disp_i_rs2en;
    assign oitfrd_match_disprd  = md & disp_i_rdwen;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q   <= '0;
            rdwen_q <= '0;
            alc_q   <= '0;
            rtp_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rdidx_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else begin
            vld_q   <= vld_d;
            rdwen_q <= rdwen_d;
            rdidx_q <= rdidx_d;
            pc_q    <= pc_d;
            alc_q   <= alc_d;
            rtp_q   <= rtp_d;
        end
    end
endmodule
